fp_div_seq: RTL
===============

// Module: fp_div_seq
// PURPOSE
//  Sequential IEEE-754 single-precision divider, the inverse-direction companion of the combinational FP multiplier.
//  Computes Out = InA / InB with a restoring mantissa divider, one quotient bit per clock.
//  Sits beside the multiplier in the FP ALU datapath; valid/ready on both sides lets the ALU stall around it.
//  Special-case conventions (flush, exception-to-zero) match the multiplier.
// PARAMETERS
//  EXP_W  8    exponent field width
//  MAN_W  23   stored mantissa width
//  BIAS   127  exponent bias
//  ITERS  26   quotient bits produced (MAN_W+3)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands present
//  in_ready   out  1   divider idle, can accept
//  InA        in   32  dividend
//  InB        in   32  divisor
//  out_valid  out  1   result valid, held until taken
//  out_ready  in   1   consumer accepts result
//  Out        out  32  quotient
// BEHAVIOUR
//  Reset values:
//   - in_ready=1, out_valid=0, Out=0, state=IDLE.
//   - Reset mid-operation aborts; the result is discarded.
//  Handshake:
//   - in_ready = (state==IDLE). Accept on the edge where in_valid & in_ready; InA/InB are registered then.
//   - Out and out_valid hold stable while out_valid & !out_ready.
//   - in_valid outside IDLE is ignored.
//  FSM: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
//   - IDLE -> DONE directly on accept of a special case.
//   - DONE -> IDLE on out_ready; in_ready rises the next cycle, so there is no same-edge re-accept.
//  Latency:
//   - special case: out_valid high 1 edge after accept.
//   - normal: out_valid high ITERS+2 = 28 edges after accept.
//  Special cases, in priority order; S = InA[31]^InB[31]:
//   1. Either exponent all-ones -> Out = 32'h0.
//   2. EA == 0 -> {S,31'd0}; denormals are flushed.
//   3. EB == 0 -> {S,8'hFF,23'd0}, divide by zero.
//  Normal path:
//   - MA = {1,InA[22:0]}, MB = {1,InB[22:0]}.
//   - Q = floor(MA*2^25/MB), 26 bits; R = remainder.
//  Normalisation:
//   - Q[25]=1: man=Q[24:2], rnd=Q[1], stk=Q[0]|(R!=0), E=EA-EB+BIAS.
//   - Q[25]=0: man=Q[23:1], rnd=Q[0], stk=(R!=0), E=EA-EB+BIAS-1.
//  Rounding and range:
//   - man' = man + (rnd & stk). A carry out of man' gives man'=0 and E=E+1.
//   - E is 10-bit signed.
//   - E >= 255 -> {S,8'hFF,0}; E <= 0 -> {S,31'd0}; otherwise {S,E[7:0],man'}.
// STRUCTURE
//  Package fp_pkg:
//   - EXP_W, MAN_W, BIAS.
//   - QNAN/INF/ZERO constants.
//   - state enum {IDLE,DIVIDE,NORM,DONE}.
//  Sub-module fp_div_mant_core:
//   - restoring shift/subtract iterator.
//   - ports: start, MA, MB -> Q[25:0], rem_nz, done after ITERS cycles.
//  The top level owns the FSM, special-case decode, exponent math and rounding.
// TESTING
//  1. 0x40C00000/0x40000000 -> 0x40400000; out_valid exactly 28 edges after accept.
//  2. 0x3F800000/0x40400000 -> 0x3EAAAAAB (round bit & sticky set); 0xC0C00000/0x40000000 -> 0xC0400000.
//  3. 0x3F800000/0x00000000 -> 0x7F800000 after 1 edge; 0x7F800000/0x3F800000 -> 0x00000000.
//  4. 0x7F000000/0x00800000 -> 0x7F800000 (overflow); 0x00800000/0x7F000000 -> 0x00000000 (underflow).
//  5. out_ready low 10 cycles -> Out and out_valid stable, in_ready=0, new in_valid ignored.
//  6. rst at DIVIDE cycle 12 -> next edge in_ready=1, out_valid=0; the following op is unaffected.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants and FSM state type for the FP divider.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned ITERS = MAN_W + 3;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StNorm,
        StDone
    } state_e;

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: Q = floor(MA * 2^25 / MB), one quotient bit per clock.
module fp_div_mant_core
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [MAN_W:0]   i_ma,
    input  logic [MAN_W:0]   i_mb,
    output logic [ITERS-1:0] o_q,
    output logic             o_rem_nz,
    output logic             o_done
);

    logic [MAN_W+1:0] r_rem;
    logic [MAN_W:0]   r_div;
    logic [ITERS-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic             w_ge;
    logic [MAN_W+1:0] w_sel;

    assign w_ge  = (r_rem >= {1'b0, r_div});
    assign w_sel = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= {1'b0, i_ma};
            r_div  <= i_mb;
            r_q    <= '0;
            r_cnt  <= CNT_W'(ITERS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // Partial remainder stays below MB, so the left shift never loses a bit.
            r_q   <= {r_q[ITERS-2:0], w_ge};
            r_rem <= w_sel << 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the final iteration; o_q/o_rem_nz are final after that edge.
    assign o_done   = r_busy && (r_cnt == CNT_W'(1));
    assign o_q      = r_q;
    assign o_rem_nz = |r_rem;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider with valid/ready on both sides.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out
);

    state_e r_state, w_state_next;

    logic             r_sign;
    logic [EXP_W-1:0] r_exp_a;
    logic [EXP_W-1:0] r_exp_b;
    logic [31:0]      r_out;

    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic             w_sign_in;
    logic             w_accept;
    logic             w_spec;
    logic [31:0]      w_spec_val;

    logic [ITERS-1:0] w_q;
    logic             w_rem_nz;
    logic             w_core_done;

    assign w_ea      = InA[30:23];
    assign w_eb      = InB[30:23];
    assign w_sign_in = InA[31] ^ InB[31];
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = ZERO;
        if ((w_ea == '1) || (w_eb == '1)) begin
            w_spec_val = ZERO;
        end else if (w_ea == '0) begin
            w_spec_val = {w_sign_in, ZERO[30:0]};
        end else if (w_eb == '0) begin
            w_spec_val = {w_sign_in, INF[30:0]};
        end else begin
            w_spec = 1'b0;
        end
    end

    fp_div_mant_core u_core (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && !w_spec),
        .i_ma     ({1'b1, InA[MAN_W-1:0]}),
        .i_mb     ({1'b1, InB[MAN_W-1:0]}),
        .o_q      (w_q),
        .o_rem_nz (w_rem_nz),
        .o_done   (w_core_done)
    );

    logic signed [9:0] w_e_base;
    logic signed [9:0] w_e;
    logic signed [9:0] w_e_fin;
    logic [MAN_W-1:0]  w_man;
    logic [MAN_W-1:0]  w_man_fin;
    logic [MAN_W:0]    w_man_sum;
    logic              w_rnd;
    logic              w_stk;
    logic [31:0]       w_norm_val;

    assign w_e_base = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b})
                    + $signed(10'(BIAS));

    always_comb begin
        w_man      = '0;
        w_rnd      = 1'b0;
        w_stk      = 1'b0;
        w_e        = w_e_base;
        w_man_sum  = '0;
        w_man_fin  = '0;
        w_e_fin    = '0;
        w_norm_val = ZERO;

        if (w_q[ITERS-1]) begin
            w_man = w_q[ITERS-2:2];
            w_rnd = w_q[1];
            w_stk = w_q[0] | w_rem_nz;
        end else begin
            w_man = w_q[ITERS-3:1];
            w_rnd = w_q[0];
            w_stk = w_rem_nz;
            w_e   = w_e_base - 10'sd1;
        end

        // Rounds up only when both guard and sticky are set.
        w_man_sum = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rnd & w_stk};
        if (w_man_sum[MAN_W]) begin
            w_man_fin = '0;
            w_e_fin   = w_e + 10'sd1;
        end else begin
            w_man_fin = w_man_sum[MAN_W-1:0];
            w_e_fin   = w_e;
        end

        if (w_e_fin >= 10'sd255) begin
            w_norm_val = {r_sign, INF[30:0]};
        end else if (w_e_fin <= 10'sd0) begin
            w_norm_val = {r_sign, ZERO[30:0]};
        end else begin
            w_norm_val = {r_sign, w_e_fin[EXP_W-1:0], w_man_fin};
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_spec ? StDone : StDivide;
                end
            end
            StDivide: begin
                if (w_core_done) begin
                    w_state_next = StNorm;
                end
            end
            StNorm: begin
                w_state_next = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_exp_a <= '0;
            r_exp_b <= '0;
            r_out   <= ZERO;
        end else begin
            if (w_accept) begin
                r_sign  <= w_sign_in;
                r_exp_a <= w_ea;
                r_exp_b <= w_eb;
                if (w_spec) begin
                    r_out <= w_spec_val;
                end
            end
            if (r_state == StNorm) begin
                r_out <= w_norm_val;
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign Out       = r_out;

endmodule
